// File: rtl/ram_burst_master_pkg.sv
// Shared types and defaults for the RAM burst master.
// Holds the FSM state encoding, the DEPTH/WIDTH defaults and the address
// increment helper that wraps modulo DEPTH.
package ram_burst_master_pkg;

    localparam int unsigned DEPTH_DEF  = 64;
    localparam int unsigned WIDTH_DEF  = 8;
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned LEN_W      = 6;
    localparam int unsigned MEM_ADDR_W = 8;
    localparam int unsigned ISSUE_W    = 7;   // holds len+1 up to 64

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        READ   = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Next word address, wrapping at depth-1.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a,
                                                   input int unsigned depth);
        return (32'(a) == depth - 32'd1) ? '0 : a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/ram_burst_master_skid.sv
// rd_skid2: two-entry skid buffer for the read-data stream.
// When empty, the incoming word is presented on the output in the same cycle
// it arrives (bypass); a word that is not consumed is stored so the output
// stays stable under backpressure.
// Ports: clk, reset (sync, active-high); in_valid/in_data from the RAM;
//        out_valid/out_data/out_ready toward the consumer; count = stored words.
module rd_skid2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;
    logic [1:0]       cnt;
    logic             push;
    logic             pop;

    // Output side: stored head first, otherwise bypass the arriving word.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        count     = 2'd0;
        push      = 1'b0;
        pop       = 1'b0;
        if (!reset) begin
            out_valid = (cnt != 2'd0) || in_valid;
            if (cnt != 2'd0) begin
                out_data = e0;
            end else if (in_valid) begin
                out_data = in_data;
            end
            count = cnt;
            pop   = out_valid && out_ready && (cnt != 2'd0);
            // A bypassed word consumed in its arrival cycle is never stored.
            push  = in_valid && !((cnt == 2'd0) && out_ready);
        end
    end

    // Storage update.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 2'd0;
            e0  <= '0;
            e1  <= '0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (push) begin
                        e0  <= in_data;
                        cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        e0 <= in_data;
                    end else if (pop) begin
                        cnt <= 2'd0;
                    end else if (push) begin
                        e1  <= in_data;
                        cnt <= 2'd2;
                    end
                end
                default: begin
                    if (pop) begin
                        e0 <= e1;
                        if (push) begin
                            e1 <= in_data;
                        end else begin
                            cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_burst_master.sv
// ram_burst_master: issues write or read bursts to a synchronous-output RAM.
// Ports: clk, reset (sync, active-high);
//        cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len  - burst command;
//        wr_data/wr_valid/wr_ready                       - write-data stream;
//        rd_data/rd_valid/rd_ready/rd_last               - read-data stream;
//        busy, done                                      - status;
//        address_out/data_out/write_en/data_in           - RAM port.
module ram_burst_master
    import ram_burst_master_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done,
    output logic [MEM_ADDR_W-1:0] address_out,
    output logic [WIDTH-1:0]      data_out,
    output logic                  write_en,
    input  logic [WIDTH-1:0]      data_in
);

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_W-1:0]       addr;
    logic [LEN_W-1:0]        rem;          // beats left to transfer, minus one
    logic [ISSUE_W-1:0]      issue_left;   // reads still to issue
    logic                    inflight;     // read issued last cycle
    logic [MEM_ADDR_W-1:0]   addr_hold;
    logic [1:0]              skid_count;
    logic [2:0]              occupancy;
    logic                    wr_beat;
    logic                    rd_issue;
    logic                    rd_beat;

    assign occupancy = 3'(skid_count) + 3'(inflight);
    assign rd_beat   = rd_valid && rd_ready;
    assign rd_last   = rd_valid && (state == READ) && (rem == '0);

    rd_skid2 #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inflight),
        .in_data   (data_in),
        .out_valid (rd_valid),
        .out_data  (rd_data),
        .out_ready (rd_ready),
        .count     (skid_count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = cmd_write ? WRITE : READ;
            WRITE:   if (wr_beat && (rem == '0)) state_nxt = FINISH;
            READ:    if (rd_beat && (rem == '0)) state_nxt = FINISH;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; reset forces the idle-state values for the whole reset cycle.
    always_comb begin
        cmd_ready   = 1'b1;
        wr_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        write_en    = 1'b0;
        data_out    = '0;
        address_out = '0;
        wr_beat     = 1'b0;
        rd_issue    = 1'b0;
        if (!reset) begin
            cmd_ready   = (state == IDLE);
            wr_ready    = (state == WRITE);
            busy        = (state != IDLE);
            done        = (state == FINISH);
            wr_beat     = wr_ready && wr_valid;
            // At most two reads between RAM and consumer, so the skid never overflows.
            rd_issue    = (state == READ) && (occupancy < 3'd2) && (issue_left != '0);
            write_en    = wr_beat;
            address_out = addr_hold;
            if (wr_beat) begin
                data_out = wr_data;
            end
            if (wr_beat || rd_issue) begin
                address_out = MEM_ADDR_W'(addr);
            end
        end
    end

    // Burst datapath: address, beat counter, issue counter, in-flight flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= '0;
            rem        <= '0;
            issue_left <= '0;
            inflight   <= 1'b0;
            addr_hold  <= '0;
        end else begin
            inflight <= rd_issue;
            if (wr_beat || rd_issue) begin
                addr_hold <= MEM_ADDR_W'(addr);
            end
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr       <= cmd_addr;
                        rem        <= cmd_len;
                        issue_left <= ISSUE_W'(cmd_len) + ISSUE_W'(1);
                    end
                end
                WRITE: begin
                    if (wr_beat) begin
                        addr <= addr_inc(addr, DEPTH);
                        rem  <= rem - LEN_W'(1);
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        addr       <= addr_inc(addr, DEPTH);
                        issue_left <= issue_left - ISSUE_W'(1);
                    end
                    if (rd_beat) begin
                        rem <= rem - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed testbench for ram_burst_master with a behavioural synchronous RAM.
module tb_ram_burst_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [5:0] cmd_addr;
    logic [5:0] cmd_len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       rd_last;
    logic       busy;
    logic       done;
    logic [7:0] address_out;
    logic [7:0] data_out;
    logic       write_en;
    logic [7:0] data_in;

    logic [7:0] mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_burst_master dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_last     (rd_last),
        .busy        (busy),
        .done        (done),
        .address_out (address_out),
        .data_out    (data_out),
        .write_en    (write_en),
        .data_in     (data_in)
    );

    // Synchronous-output RAM: data_in is the word addressed in the previous cycle.
    always @(posedge clk) begin
        if (write_en) mem[address_out[5:0]] <= data_out;
        data_in <= mem[address_out[5:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_burst(input logic [5:0] a, input logic [5:0] len, input logic [7:0] d0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = len;
        #1 chk("wr_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clk);
            cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = d0 + 8'(i);
            #1;
            chk("wr_en", 32'(write_en), 32'd1);
            chk("wr_addr", 32'(address_out), 32'((int'(a) + i) % 64));
            chk("wr_data_out", 32'(data_out), 32'(8'(d0 + 8'(i))));
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        chk("wr_done", 32'(done), 32'd1);
        chk("wr_en_off", 32'(write_en), 32'd0);
        chk("wr_data_idle", 32'(data_out), 32'd0);
        @(negedge clk);
        #1;
        chk("wr_done_clear", 32'(done), 32'd0);
        chk("wr_idle", 32'(busy), 32'd0);
    endtask

    task automatic read_burst(input logic [5:0] a, input logic [5:0] len, input logic [7:0] d0);
        @(negedge clk);
        rd_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = len;
        #1 chk("rd_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("rd_first_issue_addr", 32'(address_out), 32'(a));
        chk("rd_issue_we", 32'(write_en), 32'd0);
        chk("rd_no_early_valid", 32'(rd_valid), 32'd0);
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clk);
            #1;
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_data", 32'(rd_data), 32'(8'(d0 + 8'(i))));
            chk("rd_last", 32'(rd_last), 32'(i == int'(len)));
        end
        @(negedge clk);
        #1;
        chk("rd_done", 32'(done), 32'd1);
        chk("rd_valid_after", 32'(rd_valid), 32'd0);
        @(negedge clk);
        #1 chk("rd_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] prev_addr;
        logic [7:0] prev_data;
        logic       stall_prev;
        logic       seen_done;
        int         idx;
        int         issued;

        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;

        // Values during reset.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_last", 32'(rd_last), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_address", 32'(address_out), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);

        // First cycle after reset; wr_valid in IDLE must be ignored.
        @(negedge clk);
        reset = 1'b0; wr_valid = 1'b1; wr_data = 8'hAA;
        #1;
        chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
        chk("idle_wr_ready", 32'(wr_ready), 32'd0);
        chk("idle_write_en", 32'(write_en), 32'd0);
        chk("idle_data_out", 32'(data_out), 32'd0);
        wr_valid = 1'b0;

        // Basic write and read-back.
        write_burst(6'd5, 6'd3, 8'h11);
        read_burst(6'd5, 6'd3, 8'h11);

        // Address wrap.
        write_burst(6'd62, 6'd3, 8'h21);
        read_burst(6'd62, 6'd3, 8'h21);

        // Backpressure: rd_ready pattern 1,0,0,1.
        write_burst(6'd10, 6'd7, 8'h30);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'd10; cmd_len = 6'd7; rd_ready = 1'b1;
        #1;
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd1);
        prev_addr = address_out;
        stall_prev = 1'b0; prev_data = '0; seen_done = 1'b0; idx = 0; issued = 0;
        for (int c = 0; c < 60 && !seen_done; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            rd_ready = ((c % 4) == 0) || ((c % 4) == 3);
            #1;
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (address_out != prev_addr) begin
                    chk("bp_issue_addr", 32'(address_out), 32'(10 + issued));
                    issued++;
                    prev_addr = address_out;
                    chk("bp_outstanding", 32'(issued - idx <= 2), 32'd1);
                end
                if (stall_prev) begin
                    chk("bp_hold_valid", 32'(rd_valid), 32'd1);
                    chk("bp_hold_data", 32'(rd_data), 32'(prev_data));
                end
                if (rd_valid) begin
                    chk("bp_data", 32'(rd_data), 32'(8'h30 + 8'(idx)));
                    chk("bp_last", 32'(rd_last), 32'(idx == 7));
                    if (rd_ready) idx++;
                end
                stall_prev = rd_valid && !rd_ready;
                prev_data  = rd_data;
            end
        end
        chk("bp_done_seen", 32'(seen_done), 32'd1);
        chk("bp_beats", 32'(idx), 32'd8);
        chk("bp_issued", 32'(issued), 32'd8);
        @(negedge clk);
        rd_ready = 1'b1;
        #1 chk("bp_idle", 32'(busy), 32'd0);

        // Reset in the middle of a read burst.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'd10; cmd_len = 6'd7;
        #1 chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #1 chk("mr_beat0", 32'(rd_data), 32'h30);
        @(negedge clk);
        #1 chk("mr_beat1", 32'(rd_data), 32'h31);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mr_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("mr_rst_busy", 32'(busy), 32'd0);
        chk("mr_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mr_after_rd_valid", 32'(rd_valid), 32'd0);
        chk("mr_after_busy", 32'(busy), 32'd0);
        chk("mr_after_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mr_after_address", 32'(address_out), 32'd0);
        chk("mr_after_rd_data", 32'(rd_data), 32'd0);
        read_burst(6'd5, 6'd3, 8'h11);

        // Single-beat read with a command pulse while busy.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'd62; cmd_len = 6'd0;
        #1 chk("sb_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'd0; cmd_len = 6'd5;
        #1;
        chk("sb_busy_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("sb_issue_addr", 32'(address_out), 32'd62);
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("sb_valid", 32'(rd_valid), 32'd1);
        chk("sb_data", 32'(rd_data), 32'h21);
        chk("sb_last", 32'(rd_last), 32'd1);
        @(negedge clk);
        #1;
        chk("sb_done", 32'(done), 32'd1);
        chk("sb_no_second_beat", 32'(rd_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("sb_idle", 32'(busy), 32'd0);
        chk("sb_not_write", 32'(wr_ready), 32'd0);
        chk("sb_ready_again", 32'(cmd_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_burst_master.md
RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of addressable memory words; addresses wrap modulo DEPTH.
REQ-002 SHALL have parameter WIDTH, default 8: data word width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high; high only in IDLE.
REQ-007 SHALL have port cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-008 SHALL have port cmd_addr  input  6  start address.
REQ-009 SHALL have port cmd_len  input  6  beats minus one (0 = 1 beat, 63 = 64 beats).
REQ-010 SHALL have ports wr_data  input  WIDTH, wr_valid  input  1, wr_ready  output  1: write-data stream.
REQ-011 SHALL have ports rd_data  output  WIDTH, rd_valid  output  1, rd_ready  input  1, rd_last  output  1: read-data stream.
REQ-012 SHALL have ports busy  output  1 (high while not IDLE) and done  output  1 (one-cycle pulse at burst completion).
REQ-013 SHALL have memory-port outputs address_out  8, data_out  WIDTH, write_en  1, and input data_in  WIDTH; the memory is a synchronous-output RAM: data_in holds the word addressed one cycle earlier.

Function
REQ-014 SHALL implement FSM states IDLE, WRITE, READ, FINISH.
REQ-015 IDLE -> WRITE or READ on command accept; latch cmd_addr into addr register and cmd_len into beat counter.
REQ-016 WRITE: wr_ready = 1; on each wr_valid and wr_ready beat, drive write_en = 1, address_out = {2'b00, addr}, data_out = wr_data in that same cycle; otherwise write_en = 0.
REQ-017 After each accepted beat, addr increments modulo DEPTH (63 -> 0) and the beat counter decrements.
REQ-018 Accepting the beat with counter = 0 moves WRITE -> FINISH.
REQ-019 READ: issue a read (address_out = addr, write_en = 0) only when skid occupancy plus reads in flight is < 2 and issued beats < len+1.
REQ-020 Returned data_in SHALL be captured into a 2-entry skid buffer the cycle after issue; latency from issue to earliest rd_valid = 1 cycle.
REQ-021 With rd_ready held high, reads SHALL sustain one beat per cycle; rd_data/rd_valid SHALL remain stable while rd_valid is high and rd_ready is low.
REQ-022 rd_last SHALL be high with the final beat (beat index len); consuming it moves READ -> FINISH.
REQ-023 FINISH SHALL last one cycle with done = 1, then return to IDLE; done is 0 in all other cycles.
REQ-024 cmd_valid outside IDLE SHALL be ignored (cmd_ready = 0); wr_valid outside WRITE SHALL be ignored (wr_ready = 0).
REQ-025 When not issuing a write, write_en SHALL be 0; address_out holds its last value; data_out = 0.

Reset
REQ-026 reset SHALL return the FSM to IDLE from any state, abort the burst, and flush the skid buffer and in-flight tracking.
REQ-027 Values held during reset and in the first cycle after it: cmd_ready = 1, wr_ready = 0, rd_valid = 0, rd_last = 0, rd_data = 0, busy = 0, done = 0, write_en = 0, address_out = 0, data_out = 0.
REQ-028 A read returning in the cycle after reset SHALL be discarded.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration and the DEPTH/WIDTH defaults.
REQ-030 The 2-entry skid buffer SHALL be a sub-module rd_skid2 with ports clk, reset, in_valid, in_data, out_valid, out_data, out_ready, and count.

Verification
REQ-031 Write burst with addr = 5, len = 3, data 0x11..0x14, wr_valid held high -> write_en high for 4 consecutive cycles at addresses 5, 6, 7, 8; done pulses on the following cycle.
REQ-032 Read back addr = 5, len = 3, rd_ready = 1 -> rd_data 0x11, 0x12, 0x13, 0x14 on consecutive cycles, first beat 1 cycle after the first issue; rd_last on 0x14.
REQ-033 Wrap case: write addr = 62, len = 3 -> addresses 62, 63, 0, 1; a read of the same range returns the same data in order.
REQ-034 Backpressure: read len = 7 with rd_ready toggling 1, 0, 0, 1 -> no beat lost or duplicated, at most 2 reads outstanding, rd_data stable while stalled.
REQ-035 Assert reset in the middle of a read burst (after beat 2 of 8) -> next cycle rd_valid = 0, busy = 0, cmd_ready = 1; a new command is accepted normally.
REQ-036 Single-beat read (len = 0) with a cmd_valid pulse while busy -> exactly one beat with rd_last = 1; the second command is not accepted until IDLE.
